// File: rtl/smg_bcd_module.sv
// smg_bcd_module: 20-bit binary to six packed BCD digits by iterative
// double-dabble, with leading-zero blank mask and saturation flag.
// Digit n of BCD_Data / bit n of Blank_Mask line up with scan bit n.
module smg_bcd_module #(
  parameter logic [19:0] NUM_MAX = 20'd999999,
  parameter logic [4:0]  ITER    = 5'd20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start_Sig,
  input  logic [19:0] Number_Data,
  output logic        Busy_Sig,
  output logic        Done_Sig,
  output logic [23:0] BCD_Data,
  output logic [5:0]  Blank_Mask,
  output logic        Overflow_Flag
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [19:0] bin_r;
  logic [23:0] bcd_r;
  logic [4:0]  cnt;
  logic        ovf_r;

  logic [23:0] bcd_adj;
  logic [5:0]  blank_nxt;

  // add-3 correction on every nibble that would overflow a decimal digit
  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = bcd_r[4*i +: 4];
    end
  end

  // leading-zero mask: a digit blanks only if every digit to its left blanks;
  // the rightmost digit always shows
  always_comb begin
    blank_nxt    = '0;
    blank_nxt[5] = (bcd_r[23:20] == 4'd0);
    blank_nxt[4] = blank_nxt[5] && (bcd_r[19:16] == 4'd0);
    blank_nxt[3] = blank_nxt[4] && (bcd_r[15:12] == 4'd0);
    blank_nxt[2] = blank_nxt[3] && (bcd_r[11:8]  == 4'd0);
    blank_nxt[1] = blank_nxt[2] && (bcd_r[7:4]   == 4'd0);
    blank_nxt[0] = 1'b0;
  end

  // conversion FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      bin_r         <= '0;
      bcd_r         <= '0;
      cnt           <= '0;
      ovf_r         <= 1'b0;
      Busy_Sig      <= 1'b0;
      Done_Sig      <= 1'b0;
      BCD_Data      <= '0;
      Blank_Mask    <= 6'b111110;
      Overflow_Flag <= 1'b0;
    end else begin
      Done_Sig <= 1'b0;
      case (state)
        IDLE: begin
          if (Start_Sig) begin
            bin_r    <= (Number_Data > NUM_MAX) ? NUM_MAX : Number_Data;
            ovf_r    <= (Number_Data > NUM_MAX);
            bcd_r    <= '0;
            cnt      <= '0;
            Busy_Sig <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_r, bin_r} <= {bcd_adj[22:0], bin_r, 1'b0};
          cnt            <= cnt + 5'd1;
          if (cnt == ITER - 5'd1)
            state <= DONE;
        end
        DONE: begin
          BCD_Data      <= bcd_r;
          Blank_Mask    <= blank_nxt;
          Overflow_Flag <= ovf_r;
          Done_Sig      <= 1'b1;
          Busy_Sig      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smg_bcd_module.sv
// Directed testbench for smg_bcd_module.
module tb_smg_bcd_module;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start_Sig;
  logic [19:0] Number_Data;
  logic        Busy_Sig;
  logic        Done_Sig;
  logic [23:0] BCD_Data;
  logic [5:0]  Blank_Mask;
  logic        Overflow_Flag;

  int total = 0;
  int bad   = 0;

  smg_bcd_module #(.NUM_MAX(20'd999999), .ITER(5'd20)) dut (
    .CLK(CLK),
    .RST(RST),
    .Start_Sig(Start_Sig),
    .Number_Data(Number_Data),
    .Busy_Sig(Busy_Sig),
    .Done_Sig(Done_Sig),
    .BCD_Data(BCD_Data),
    .Blank_Mask(Blank_Mask),
    .Overflow_Flag(Overflow_Flag)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, sample 1 time unit after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // one complete conversion; optionally scrambles Number_Data after E0
  task automatic run(input string tag, input logic [19:0] val, input logic [23:0] exp_bcd,
                     input logic [5:0] exp_mask, input logic exp_ovf, input bit scramble);
    int done_at;
    int busy_cnt;
    done_at  = -1;
    busy_cnt = 0;
    Number_Data = val;
    Start_Sig   = 1'b1;
    tick();                       // E0
    Start_Sig = 1'b0;
    if (Busy_Sig) busy_cnt++;
    for (int n = 1; n <= 40; n++) begin
      if (scramble) Number_Data = 20'($urandom);
      if (n == 5) Start_Sig = 1'b1;   // ignored while busy
      if (n == 6) Start_Sig = 1'b0;
      tick();
      if (Done_Sig) begin
        done_at = n;
        break;
      end
      if (Busy_Sig) busy_cnt++;
    end
    chk({tag, "_lat"},  done_at, 21);
    chk({tag, "_busy"}, busy_cnt, 21);
    chk({tag, "_bcd"},  BCD_Data, exp_bcd);
    chk({tag, "_mask"}, Blank_Mask, exp_mask);
    chk({tag, "_ovf"},  Overflow_Flag, exp_ovf);
    tick();
    chk({tag, "_pulse"}, Done_Sig, 1'b0);
    chk({tag, "_hold"},  BCD_Data, exp_bcd);
  endtask

  initial begin
    int k;
    int ndone;
    int pos [3];
    RST = 1'b1; Start_Sig = 1'b0; Number_Data = '0;
    tick(); tick();
    chk("rst_busy", Busy_Sig, 1'b0);
    chk("rst_done", Done_Sig, 1'b0);
    chk("rst_bcd",  BCD_Data, 24'h000000);
    chk("rst_mask", Blank_Mask, 6'b111110);
    chk("rst_ovf",  Overflow_Flag, 1'b0);
    RST = 1'b0;
    tick();

    run("v123456", 20'd123456, 24'h123456, 6'b000000, 1'b0, 1'b0);
    run("v42",     20'd42,     24'h000042, 6'b111100, 1'b0, 1'b0);
    run("v0",      20'd0,      24'h000000, 6'b111110, 1'b0, 1'b0);
    run("vmax",    20'd999999, 24'h999999, 6'b000000, 1'b0, 1'b0);
    run("vsat",    20'hFFFFF,  24'h999999, 6'b000000, 1'b1, 1'b0);
    run("v7",      20'd7,      24'h000007, 6'b111110, 1'b0, 1'b0);
    run("vscr",    20'd654321, 24'h654321, 6'b000000, 1'b0, 1'b1);

    // Start held high: accepts at E0, E22, E44 -> Done at E21, E43, E65
    Number_Data = 20'd100000;
    Start_Sig   = 1'b1;
    tick();                       // E0
    ndone = 0;
    for (k = 1; k <= 70; k++) begin
      tick();
      if (Done_Sig) begin
        if (ndone < 3) pos[ndone] = k;
        ndone++;
        chk("held_bcd",  BCD_Data, 24'h100000);
        chk("held_mask", Blank_Mask, 6'b000000);
      end
      if (ndone == 3) break;
    end
    Start_Sig = 1'b0;
    chk("held_count", ndone, 3);
    chk("held_pos0", pos[0], 21);
    chk("held_pos1", pos[1], 43);
    chk("held_pos2", pos[2], 65);
    for (int n = 0; n < 25; n++) tick();

    // reset at E10 aborts a conversion
    Number_Data = 20'd555555;
    Start_Sig   = 1'b1;
    tick();                       // E0
    Start_Sig = 1'b0;
    for (int n = 1; n <= 9; n++) tick();
    RST = 1'b1;
    tick();                       // E10
    RST = 1'b0;
    chk("abort_busy", Busy_Sig, 1'b0);
    chk("abort_bcd",  BCD_Data, 24'h000000);
    chk("abort_mask", Blank_Mask, 6'b111110);
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (Done_Sig) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    run("v1", 20'd1, 24'h000001, 6'b111110, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
